// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// ysyx_23060096_rf_wb_arbiter
// Shares the register-file write port between NREQ writeback requesters and
// keeps a per-register busy scoreboard for RAW hazard detection by issue logic.
// Build option: define YSYX_23060096_RF_WB_RR_EN for round-robin arbitration;
// otherwise fixed priority with index 0 highest and no rotating pointer.
module ysyx_23060096_rf_wb_arbiter #(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       wb_stall,
  output logic                       w_en,
  output logic [ADDR_WIDTH-1:0]      waddr,
  output logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_rd,
  input  logic [ADDR_WIDTH-1:0]      ra,
  input  logic [ADDR_WIDTH-1:0]      rb,
  output logic                       busy_a,
  output logic                       busy_b
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  arb_en;
  logic [NREQ-1:0]       grant;
  logic                  any_grant;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;

  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  // Grants are suppressed while in reset and while the writeback path is frozen.
  assign arb_en = rstn & ~wb_stall;

`ifdef YSYX_23060096_RF_WB_RR_EN
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d;
  int            best_dist;
  int            win;
  int            dist;

  // Rotating priority: the valid requester at the smallest wrapped distance from ptr wins.
  always_comb begin
    grant     = '0;
    ptr_d     = ptr_q;
    best_dist = NREQ;
    win       = 0;
    dist      = 0;
    for (int i = 0; i < NREQ; i++) begin
      dist = i - int'(ptr_q);
      if (dist < 0) dist = dist + NREQ;
      if (req_valid[i] && (dist < best_dist)) begin
        best_dist = dist;
        win       = i;
      end
    end
    if (arb_en && (best_dist < NREQ)) begin
      for (int i = 0; i < NREQ; i++) grant[i] = (i == win);
      ptr_d = (win == NREQ - 1) ? '0 : PW'(win + 1);
    end
  end

  // Pointer moves just past the winner; it holds when nothing is granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  logic found;

  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_en && req_valid[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  assign req_ready = grant;
  assign any_grant = |grant;

  // Route the winning requester's address and data to the write stage.
  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next write-port contents: x0 transfers are consumed but never enable a write.
  always_comb begin
    w_en_d  = any_grant && (g_addr != '0);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (any_grant) begin
      waddr_d = g_addr;
      wdata_d = g_data;
    end
  end

  // Write port register: one cycle after the grant edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_en_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      w_en_q  <= w_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Scoreboard next state: clear at grant, then set from issue so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (any_grant) busy_d[g_addr] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign w_en   = w_en_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign busy_a = busy_q[ra];
  assign busy_b = busy_q[rb];

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// Bench for ysyx_23060096_rf_wb_arbiter: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_ysyx_23060096_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               wb_stall = 1'b0;
  logic               w_en;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic               iss_valid = 1'b0;
  logic [AW-1:0]      iss_rd = '0;
  logic [AW-1:0]      ra = '0;
  logic [AW-1:0]      rb = '0;
  logic               busy_a;
  logic               busy_b;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  ysyx_23060096_rf_wb_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wb_stall(wb_stall),
    .w_en(w_en), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .ra(ra), .rb(rb), .busy_a(busy_a), .busy_b(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] v, input logic st, input int p);
    logic [NREQ-1:0] r;
    r = '0;
    if (!st && (v != '0)) begin
`ifdef YSYX_23060096_RF_WB_RR_EN
      for (int k = NREQ - 1; k >= 0; k--) begin
        int idx;
        idx = (p + k) % NREQ;
        if (((v >> idx) & NREQ'(1)) != '0) r = NREQ'(1) << idx;
      end
`else
      r = v & (~v + NREQ'(1));
      if (p < 0) r = '0;
`endif
    end
    return r;
  endfunction

  int                 m_ptr;
  logic [31:0]        m_busy;
  logic               m_wen;
  logic [AW-1:0]      m_waddr;
  logic [DW-1:0]      m_wdata;
  logic [NREQ-1:0]    m_last_grant;
  logic [AW+DW-1:0]   expq[$];

  logic [NREQ-1:0]    m_g;
  int                 m_gi;
  logic [AW-1:0]      m_ga;
  logic [DW-1:0]      m_gd;

  always_comb begin
    m_g  = rstn ? exp_grant(req_valid, wb_stall, m_ptr) : '0;
    m_gi = 0;
    for (int i = 0; i < NREQ; i++) if (m_g[i]) m_gi = i;
    m_ga = req_addr[m_gi*AW +: AW];
    m_gd = req_data[m_gi*DW +: DW];
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ptr        <= 0;
      m_busy       <= '0;
      m_wen        <= 1'b0;
      m_waddr      <= '0;
      m_wdata      <= '0;
      m_last_grant <= '0;
      expq.delete();
    end else begin
      m_last_grant <= m_g;
      m_wen        <= (m_g != '0) && (m_ga != '0);
      if (m_g != '0) begin
        m_waddr <= m_ga;
        m_wdata <= m_gd;
        m_ptr   <= (m_gi + 1) % NREQ;
        if (m_ga != '0) begin
          m_busy[m_ga] <= 1'b0;
          expq.push_back({m_ga, m_gd});
        end
      end
      if (iss_valid && (iss_rd != '0)) m_busy[iss_rd] <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  task automatic compare_cycle();
    logic [AW+DW-1:0] e;
    chk("req_ready", req_ready, m_g);
    chk("ready_onehot0", $onehot0(req_ready), 1);
    chk("ready_under_stall", (wb_stall && (req_ready != '0)), 0);
    chk("w_en", w_en, m_wen);
    if (m_wen) begin
      chk("waddr", waddr, m_waddr);
      chk("wdata", wdata, m_wdata);
    end
    chk("busy_a", busy_a, m_busy[ra]);
    chk("busy_b", busy_b, m_busy[rb]);
    if (w_en === 1'b1) begin
      if (expq.size() == 0) begin
        chk("write_unexpected", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("write_order", {waddr, wdata}, e);
      end
    end
  endtask

  always @(negedge clk) if (cmp_en) compare_cycle();

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic drain();
    wb_stall = 1'b0;
    for (int k = 0; (k < 20) && (req_valid != '0); k++) begin
      step();
      req_valid = req_valid & ~m_last_grant;
    end
    chk("drain_done", req_valid, 0);
  endtask

  logic [NREQ-1:0] cont_exp [3];
  logic [NREQ-1:0] resume_exp;

  initial begin
`ifdef YSYX_23060096_RF_WB_RR_EN
    cont_exp[0] = 3'b001; cont_exp[1] = 3'b010; cont_exp[2] = 3'b100;
    resume_exp  = 3'b100;
`else
    cont_exp[0] = 3'b001; cont_exp[1] = 3'b001; cont_exp[2] = 3'b001;
    resume_exp  = 3'b001;
`endif

    // Reset state, with requests present to show ready is held low.
    #2 rstn = 1'b0;
    #1 cmp_en = 1'b1;
    req_valid = 3'b111;
    to_neg();
    to_neg();
    chk("rst_ready", req_ready, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy_a", busy_a, 0);
    req_valid = '0;
    rstn = 1'b1;

    // Single request; also issue to reg 9 to populate the scoreboard.
    step();
    req_valid = 3'b001; set_req(0, 3, 32'hDEADBEEF);
    iss_valid = 1'b1; iss_rd = 5'd9; ra = 5'd9;
    to_neg();
    chk("single_ready", req_ready, 3'b001);
    step();
    req_valid = '0; iss_valid = 1'b0;
    to_neg();
    chk("single_w_en", w_en, 1);
    chk("single_waddr", waddr, 3);
    chk("single_wdata", wdata, 32'hDEADBEEF);
    chk("single_busy9", busy_a, 1);
    step();
    to_neg();
    chk("single_w_en_after", w_en, 0);

    // Asynchronous reset in the middle of a write cycle.
    step();
    req_valid = 3'b001; set_req(0, 5, 32'h12345678);
    step();
    req_valid = '0;
    #1;
    chk("midrst_pre_w_en", w_en, 1);
    chk("midrst_pre_waddr", waddr, 5);
    rstn = 1'b0;
    #1;
    chk("midrst_w_en", w_en, 0);
    chk("midrst_waddr", waddr, 0);
    chk("midrst_wdata", wdata, 0);
    chk("midrst_busy_a", busy_a, 0);
    to_neg();
    rstn = 1'b1;

    // Contention: all three requesters held valid.
    step();
    req_valid = 3'b111;
    set_req(0, 1, 32'hA0); set_req(1, 2, 32'hA1); set_req(2, 3, 32'hA2);
    for (int c = 0; c < 3; c++) begin
      to_neg();
      chk("contention_grant", req_ready, cont_exp[c]);
      if (c < 2) step();
    end
    drain();

    // x0 request is consumed without a write; stall blocks grants and holds ptr.
    req_valid = 3'b010; set_req(1, 0, 32'h55);
    to_neg();
    chk("x0_ready", req_ready, 3'b010);
    step();
    req_valid = '0;
    to_neg();
    chk("x0_w_en", w_en, 0);
    step();
    wb_stall = 1'b1;
    req_valid = 3'b011; set_req(0, 4, 32'h44); set_req(1, 6, 32'h66);
    to_neg();
    chk("stall_ready", req_ready, 0);
    step();
    to_neg();
    chk("stall_ready_hold", req_ready, 0);
    chk("stall_w_en", w_en, 0);
    step();
    wb_stall = 1'b0;
    req_valid = 3'b111; set_req(2, 8, 32'h88);
    to_neg();
    chk("stall_resume_grant", req_ready, resume_exp);
    drain();

    // Scoreboard set, clear at grant, and set-wins on the same edge.
    step();
    iss_valid = 1'b1; iss_rd = 5'd7; ra = 5'd7; rb = 5'd0;
    step();
    iss_valid = 1'b0;
    req_valid = 3'b001; set_req(0, 7, 32'h77);
    to_neg();
    chk("sb_set", busy_a, 1);
    chk("sb_r0", busy_b, 0);
    step();
    req_valid = '0;
    to_neg();
    chk("sb_clear", busy_a, 0);
    chk("sb_clear_waddr", waddr, 7);
    step();
    iss_valid = 1'b1; iss_rd = 5'd7;
    req_valid = 3'b001; set_req(0, 7, 32'h78);
    step();
    iss_valid = 1'b0;
    req_valid = '0;
    to_neg();
    chk("sb_set_wins", busy_a, 1);
    chk("sb_set_wins_w_en", w_en, 1);
    chk("sb_set_wins_wdata", wdata, 32'h78);

    // Random stress against the model.
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || m_last_grant[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_req(i, $urandom_range(0, 31), $urandom);
        end
      end
      wb_stall  = ($urandom_range(0, 4) == 0);
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = AW'($urandom_range(0, 31));
      ra        = AW'($urandom_range(0, 31));
      rb        = AW'($urandom_range(0, 31));
    end
    iss_valid = 1'b0;
    drain();
    step();
    step();
    to_neg();
    chk("all_writes_seen", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
